// File: rtl/cb_dinb_router_if.sv
// Handshake bundle for the CB port-B lane router: input beat stream and mapped output stream.
interface cb_dinb_router_if #(
  parameter int unsigned X      = 4,
  parameter int unsigned L      = 4,
  parameter int unsigned RSA_DW = 16,
  parameter int unsigned OFS_W  = (L > 1) ? $clog2(L) : 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_mode;
  logic [OFS_W-1:0]      in_offset;
  logic [X*RSA_DW-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [L*RSA_DW-1:0]   out_data;
  logic [L-1:0]          out_wen;

  modport slave (
    input  in_valid, in_mode, in_offset, in_data, out_ready,
    output in_ready, out_valid, out_data, out_wen
  );

  modport master (
    output in_valid, in_mode, in_offset, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_wen
  );
endinterface

// File: rtl/cb_dinb_router.sv
// Maps X-lane array beats onto L CB lanes (pass/rev/rot/landmark insert/pack) with per-lane
// write enables, buffered in a 2-entry output FIFO.
module cb_dinb_router #(
  parameter int unsigned X      = 4,
  parameter int unsigned L      = 4,
  parameter int unsigned RSA_DW = 16,
  parameter int unsigned LM     = 2,
  parameter int unsigned OFS_W  = (L > 1) ? $clog2(L) : 1
) (
  input  logic            clk,
  input  logic            sys_rst_n,
  cb_dinb_router_if.slave bus,
  output logic            err,
  input  logic            err_clr
);
  localparam int unsigned DW = L * RSA_DW;
  localparam int unsigned HW = LM * RSA_DW;

  localparam logic [2:0] ModePass = 3'd0;
  localparam logic [2:0] ModeRev  = 3'd1;
  localparam logic [2:0] ModeRot  = 3'd2;
  localparam logic [2:0] ModeNew  = 3'd3;
  localparam logic [2:0] ModePack = 3'd4;

  typedef enum logic [0:0] {PEmpty, PHalf} pack_e;

  pack_e           pstate_q, pstate_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            err_q, err_d, err_set;
  logic [1:0]      cnt_q, cnt_d;
  logic [DW-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [L-1:0]    head_wen_q, head_wen_d, tail_wen_q, tail_wen_d;
  logic [DW-1:0]   map_data;
  logic [L-1:0]    map_wen;
  logic            accept, emit, pop, bad_mode, bad_ofs;

  assign bus.in_ready  = sys_rst_n & (cnt_q != 2'd2);
  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = head_data_q;
  assign bus.out_wen   = head_wen_q;
  assign err           = err_q;

  assign accept   = bus.in_valid & bus.in_ready;
  assign pop      = bus.out_valid & bus.out_ready;
  assign bad_mode = (bus.in_mode > ModePack);
  assign bad_ofs  = ((bus.in_mode == ModeRot) || (bus.in_mode == ModeNew)) &&
                    (int'(bus.in_offset) >= int'(L));

  // Lane mapping and PACK state machine
  always_comb begin
    map_data = '0;
    map_wen  = '0;
    emit     = 1'b0;
    err_set  = 1'b0;
    pstate_d = pstate_q;
    hold_d   = hold_q;
    if (accept) begin
      if (bad_mode || bad_ofs) begin
        // Illegal beats are swallowed; a pending half-pack survives them.
        err_set = 1'b1;
      end else if (bus.in_mode == ModePack) begin
        if (pstate_q == PEmpty) begin
          hold_d   = bus.in_data[HW-1:0];
          pstate_d = PHalf;
        end else begin
          emit                  = 1'b1;
          map_data[HW-1:0]      = hold_q;
          map_data[2*HW-1:HW]   = bus.in_data[HW-1:0];
          map_wen[2*LM-1:0]     = '1;
          pstate_d              = PEmpty;
          hold_d                = '0;
        end
      end else begin
        emit = 1'b1;
        if (pstate_q == PHalf) begin
          err_set  = 1'b1;
          pstate_d = PEmpty;
          hold_d   = '0;
        end
        case (bus.in_mode)
          ModePass: begin
            for (int i = 0; i < int'(X); i++) begin
              map_data[i*RSA_DW +: RSA_DW] = bus.in_data[i*RSA_DW +: RSA_DW];
              map_wen[i]                   = 1'b1;
            end
          end
          ModeRev: begin
            for (int i = 0; i < int'(L); i++) begin
              if (int'(L) - 1 - i < int'(X)) begin
                map_data[i*RSA_DW +: RSA_DW] = bus.in_data[(int'(L)-1-i)*RSA_DW +: RSA_DW];
                map_wen[i]                   = 1'b1;
              end
            end
          end
          ModeRot: begin
            for (int i = 0; i < int'(X); i++) begin
              int dst;
              dst = (i + int'(bus.in_offset)) % int'(L);
              map_data[dst*RSA_DW +: RSA_DW] = bus.in_data[i*RSA_DW +: RSA_DW];
              map_wen[dst]                   = 1'b1;
            end
          end
          default: begin // ModeNew
            for (int j = 0; j < int'(LM); j++) begin
              int dst;
              dst = (j + int'(bus.in_offset)) % int'(L);
              map_data[dst*RSA_DW +: RSA_DW] = bus.in_data[j*RSA_DW +: RSA_DW];
              map_wen[dst]                   = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  // Output FIFO: empty slots are kept zero so the head drives zeros when out_valid is low.
  always_comb begin
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_wen_d  = head_wen_q;
    tail_data_d = tail_data_q;
    tail_wen_d  = tail_wen_q;
    unique case ({emit, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          head_data_d = map_data;
          head_wen_d  = map_wen;
        end else begin
          tail_data_d = map_data;
          tail_wen_d  = map_wen;
        end
      end
      2'b01: begin
        cnt_d       = cnt_q - 2'd1;
        head_data_d = tail_data_q;
        head_wen_d  = tail_wen_q;
        tail_data_d = '0;
        tail_wen_d  = '0;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_data_d = map_data;
          head_wen_d  = map_wen;
        end else begin
          head_data_d = tail_data_q;
          head_wen_d  = tail_wen_q;
          tail_data_d = map_data;
          tail_wen_d  = map_wen;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pstate_q    <= PEmpty;
      hold_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_wen_q  <= '0;
      tail_data_q <= '0;
      tail_wen_q  <= '0;
    end else begin
      pstate_q    <= pstate_d;
      hold_q      <= hold_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      head_data_q <= head_data_d;
      head_wen_q  <= head_wen_d;
      tail_data_q <= tail_data_d;
      tail_wen_q  <= tail_wen_d;
    end
  end
endmodule

// File: tb/tb_cb_dinb_router.sv
// Directed bench for cb_dinb_router at X=L=4, RSA_DW=16, LM=2.
module tb_cb_dinb_router;
  localparam logic [2:0] Pass = 3'd0, Rev = 3'd1, Rot = 3'd2, New = 3'd3, Pack = 3'd4;
  localparam logic [63:0] D = 64'h0004_0003_0002_0001;

  logic clk = 1'b0;
  logic sys_rst_n;
  logic err, err_clr;
  int   n_cmp = 0;
  int   n_err = 0;
  int   seen;

  cb_dinb_router_if #(.X(4), .L(4), .RSA_DW(16), .OFS_W(2)) bus ();

  cb_dinb_router #(.X(4), .L(4), .RSA_DW(16), .LM(2), .OFS_W(2)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; offers one beat for exactly one rising edge, returns at the next negedge.
  task automatic send(input logic [2:0] mode, input logic [1:0] ofs, input logic [63:0] data);
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_offset = ofs;
    bus.in_data   = data;
    check("in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic expect_out(input string tag, input logic [63:0] data, input logic [3:0] wen);
    check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    check({tag, "_data"}, bus.out_data, data);
    check({tag, "_wen"}, {60'd0, bus.out_wen}, {60'd0, wen});
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = Pass;
    bus.in_offset = 2'd0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    err_clr       = 1'b0;
    sys_rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_data", bus.out_data, 64'd0);
    check("rst_wen", {60'd0, bus.out_wen}, 64'd0);
    sys_rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back beats: each output appears one edge after acceptance
    send(Pass, 2'd0, D); expect_out("pass", D, 4'b1111);
    send(Rev, 2'd0, D);  expect_out("rev", 64'h0001_0002_0003_0004, 4'b1111);
    send(Rot, 2'd1, D);  expect_out("rot1", 64'h0003_0002_0001_0004, 4'b1111);
    send(Rot, 2'd3, D);  expect_out("rot3", 64'h0001_0004_0003_0002, 4'b1111);
    send(New, 2'd2, D);  expect_out("new2", 64'h0002_0001_0000_0000, 4'b1100);
    send(New, 2'd3, D);  expect_out("new3", 64'h0001_0000_0000_0002, 4'b1001);

    send(Pack, 2'd0, 64'h0000_0000_00A1_00A0);
    check("packA_none", {63'd0, bus.out_valid}, 64'd0);
    send(Pack, 2'd0, 64'h0000_0000_00B1_00B0);
    expect_out("packAB", 64'h00B1_00B0_00A1_00A0, 4'b1111);
    check("packAB_err", {63'd0, err}, 64'd0);

    // Half-pack abandoned by a PASS beat
    send(Pack, 2'd0, 64'h0000_0000_00A1_00A0);
    send(Pass, 2'd0, D);
    expect_out("abandon", D, 4'b1111);
    check("abandon_err", {63'd0, err}, 64'd1);
    @(negedge clk);
    check("abandon_only", {63'd0, bus.out_valid}, 64'd0);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", {63'd0, err}, 64'd0);

    send(3'd6, 2'd0, D);
    check("mode6_none", {63'd0, bus.out_valid}, 64'd0);
    check("mode6_err", {63'd0, err}, 64'd1);

    // Set and clear in the same cycle: set wins
    err_clr = 1'b1;
    send(3'd7, 2'd0, D);
    err_clr = 1'b0;
    check("set_wins", {63'd0, err}, 64'd1);

    // Illegal beat between PACK halves keeps the held half
    send(Pack, 2'd0, 64'h0000_0000_00A1_00A0);
    send(3'd5, 2'd0, D);
    send(Pack, 2'd0, 64'h0000_0000_00B1_00B0);
    expect_out("pack_hold", 64'h00B1_00B0_00A1_00A0, 4'b1111);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    check("pack_hold_clr", {63'd0, err}, 64'd0);

    // Backpressure: two accepts, then in_ready drops
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.in_valid  = 1'b1;
      bus.in_mode   = Pass;
      bus.in_offset = 2'd0;
      bus.in_data   = 64'(k);
      check("bp_ready", {63'd0, bus.in_ready}, (k <= 2) ? 64'd1 : 64'd0);
      @(posedge clk);
      @(negedge clk);
    end
    check("bp_full", {63'd0, bus.in_ready}, 64'd0);
    expect_out("bp_1", 64'd1, 4'b1111);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    expect_out("bp_2", 64'd2, 4'b1111);
    check("bp_reopen", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    expect_out("bp_3", 64'd3, 4'b1111);
    @(negedge clk);
    check("bp_drain", {63'd0, bus.out_valid}, 64'd0);

    // Reset with two entries queued
    bus.out_ready = 1'b0;
    send(Pass, 2'd0, 64'd5);
    send(Pass, 2'd0, 64'd6);
    check("rm_full", {63'd0, bus.in_ready}, 64'd0);
    sys_rst_n = 1'b0;
    #1;
    check("rm_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rm_data", bus.out_data, 64'd0);
    check("rm_ready", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    sys_rst_n     = 1'b1;
    bus.out_ready = 1'b1;
    seen          = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("rm_no_emit", 64'(seen), 64'd0);
    check("rm_ready_back", {63'd0, bus.in_ready}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cb_dinb_router.md
# cb_dinb_router

Parametrised, flow-controlled lane router for the covariance-buffer port-B write path. It takes X-lane beats from the systolic array's C output and maps them onto L CB lanes. Supported maps are pass, reverse, rotate by a runtime offset, landmark insert at a runtime lane offset, and two-beat landmark packing. Each output beat carries a per-lane write enable. The result is buffered in a 2-entry output FIFO with valid/ready handshakes on both sides, feeding the CB port-B write sequencer.

## Interface
Parameters:
- X, 4, input lane count; constraint X <= L
- L, 4, CB lane count (output lanes)
- RSA_DW, 16, bits per lane
- LM, 2, lanes per landmark; constraint 2*LM <= L
- OFS_W, $clog2(L) (min 1), width of lane offset

Ports:
- clk  in  1  system clock; all state on rising edge
- sys_rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_mode  in  3  0 PASS, 1 REV, 2 ROT, 3 NEW, 4 PACK, 5-7 illegal
- in_offset  in  OFS_W  lane offset for ROT/NEW
- in_data  in  X*RSA_DW  lane i = in_data[i*RSA_DW +: RSA_DW]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_data  out  L*RSA_DW  mapped lanes
- out_wen  out  L  per-lane write enable
- err  out  1  sticky error flag
- err_clr  in  1  synchronous clear of err

## Operation
- Lane maps, per accepted beat. Unwritten lanes carry data 0 and wen 0:
  - PASS: out lane i = in lane i for i<X; wen[i]=1 for i<X.
  - REV: out lane i = in lane L-1-i when L-1-i < X, else 0. wen follows the same condition.
  - ROT: out lane (i+in_offset) mod L = in lane i for i<X; wen set on those lanes.
  - NEW: out lane (in_offset+j) mod L = in lane j for j<LM; wen only on those LM lanes.
  - PACK: the first beat's lanes 0..LM-1 go to the hold register and produce no output. The second PACK beat emits lanes 0..LM-1 = held data and lanes LM..2LM-1 = second beat's lanes 0..LM-1, with wen set on lanes 0..2LM-1.
- PACK state machine:
  - States: P_EMPTY and P_HALF.
  - P_EMPTY + PACK accept -> P_HALF.
  - P_HALF + PACK accept -> emit, then P_EMPTY.
  - P_HALF + non-PACK accept -> set err, discard the held half, process the beat normally, then P_EMPTY.
- Illegal beats:
  - in_mode 5-7: beat consumed, nothing emitted, err set.
  - ROT/NEW with in_offset >= L (only possible for non-power-of-2 L): beat consumed, nothing emitted, err set.
  - Neither case changes the PACK state, except that P_HALF is preserved.
- err:
  - Set by any of the above.
  - Cleared by err_clr; if set and clear occur in the same cycle, set wins.
- FIFO:
  - 2 entries, each holding data plus wen; strict in-order delivery.
  - out_data/out_wen come from the head entry and are registered.
  - Contents are held stable while out_valid & !out_ready.
  - out_data and out_wen are all-zero whenever out_valid=0.
- in_ready = sys_rst_n & (count < 2). It does not depend on out_ready, so there is no combinational ready path.
  - Non-emitting beats (PACK first half, illegal) still require in_ready.
- Push and pop in the same cycle with count=1: count stays 1, zero bubble.

## Timing
- Reset values, asynchronous on sys_rst_n low: out_valid=0, out_data=0, out_wen=0, err=0, in_ready=0, FIFO count=0, PACK state=P_EMPTY, hold register=0.
- in_ready rises the first cycle after sys_rst_n deasserts.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n, if the FIFO was empty. For PACK, the output follows the second beat's acceptance.
- Throughput: 1 beat/cycle when out_ready is held high.
- With out_ready=0: two beats are accepted, then in_ready=0 until a pop. in_ready returns 1 the cycle after the pop edge.
- Reset mid-operation: FIFO and hold contents are lost, and no beat is emitted after release.

## Test plan
All cases use X=L=4, RSA_DW=16, LM=2, and in lanes 3..0 = 0x0004,0x0003,0x0002,0x0001 unless stated.
- PASS then REV, out_ready=1:
  - PASS out lanes 3..0 = 4,3,2,1, wen=1111, one cycle after accept.
  - REV out lanes 3..0 = 1,2,3,4, wen=1111.
- ROT offset 1 -> lanes 3..0 = 3,2,1,4, wen=1111.
- NEW offset 2 -> lanes 3..0 = 2,1,0,0, wen=1100.
- NEW offset 3 -> lanes 3..0 = 1,0,0,2, wen=1001.
- PACK A (lanes 0xA1,0xA0) then B (0xB1,0xB0) -> single output 0xB1,0xB0,0xA1,0xA0, wen=1111, err=0.
- PACK A then PASS -> err=1, only the PASS output appears. err_clr -> err=0. Mode 6 -> no output, err=1.
- out_ready=0 with 3 beats offered -> in_ready=0 after 2 accepts.
  - Releasing out_ready -> outputs arrive in order 1,2,3.
  - Asserting sys_rst_n=0 with 2 entries queued -> out_valid=0 immediately, and nothing is emitted after release.
